// File: rtl/ysyx_23060025_csr_unit.sv
// Machine-mode CSR file: combinational read, write/trap/mret update at the next edge; no backpressure.
// Optional 64-bit mcycle/minstret counters are enabled by YSYX_23060025_CSR_COUNTERS_EN.
module ysyx_23060025_csr_unit #(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] VENDOR_ID  = 32'h79737978,
   parameter logic [31:0] ARCH_ID    = 32'd23060025
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  csr_valid_i,
   input  logic [1:0]            csr_op_i,
   input  logic [11:0]           csr_addr_i,
   input  logic [DATA_WIDTH-1:0] csr_wdata_i,
   output logic [DATA_WIDTH-1:0] csr_rdata_o,
   output logic                  csr_illegal_o,
   input  logic                  trap_valid_i,
   input  logic [DATA_WIDTH-1:0] trap_cause_i,
   input  logic [DATA_WIDTH-1:0] trap_pc_i,
   input  logic                  mret_i,
   input  logic                  retire_i,
   output logic [DATA_WIDTH-1:0] trap_target_o,
   output logic [DATA_WIDTH-1:0] mret_target_o,
   output logic                  mie_o
);
   localparam int W = DATA_WIDTH;

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MARCHID   = 12'hF12;
   localparam logic [11:0] A_MHARTID   = 12'hF14;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;

   logic         mie_q, mie_d, mpie_q, mpie_d;
   logic [W-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
   logic [W-1:0] mcause_q, mcause_d, mscratch_q, mscratch_d;
   logic [W-1:0] mstatus_v, rd_val, new_val;
   logic         hit, read_only, wr_attempt, do_write;
   logic [63:0]  mcycle_q, mcycle_d, minstret_q, minstret_d;

   always_comb begin
      mstatus_v        = '0;
      mstatus_v[12:11] = 2'b11;
      mstatus_v[7]     = mpie_q;
      mstatus_v[3]     = mie_q;
   end

   // Address decode: read value, whether the address exists, and whether it is read-only.
   always_comb begin
      rd_val    = '0;
      hit       = 1'b1;
      read_only = 1'b0;
      case (csr_addr_i)
         A_MSTATUS:   rd_val = mstatus_v;
         A_MTVEC:     rd_val = mtvec_q;
         A_MSCRATCH:  rd_val = mscratch_q;
         A_MEPC:      rd_val = mepc_q;
         A_MCAUSE:    rd_val = mcause_q;
         A_MVENDORID: begin rd_val = W'(VENDOR_ID); read_only = 1'b1; end
         A_MARCHID:   begin rd_val = W'(ARCH_ID);   read_only = 1'b1; end
         A_MHARTID:   read_only = 1'b1;
`ifdef YSYX_23060025_CSR_COUNTERS_EN
         A_MCYCLE:    rd_val = mcycle_q[W-1:0];
         A_MINSTRET:  rd_val = minstret_q[W-1:0];
         A_MCYCLEH: begin
            hit    = (W == 32);
            rd_val = W'(mcycle_q[63:32]);
         end
         A_MINSTRETH: begin
            hit    = (W == 32);
            rd_val = W'(minstret_q[63:32]);
         end
`endif
         default:     hit = 1'b0;
      endcase
   end

   // RS/RC with a zero mask is a pure read, so it is neither a write nor a read-only violation.
   always_comb begin
      wr_attempt    = (csr_op_i == 2'b01) || ((csr_op_i != 2'b00) && (csr_wdata_i != '0));
      csr_illegal_o = csr_valid_i && (!hit || (read_only && wr_attempt));
      csr_rdata_o   = csr_illegal_o ? '0 : rd_val;
      do_write      = csr_valid_i && !csr_illegal_o && wr_attempt && !trap_valid_i && !mret_i;
      case (csr_op_i)
         2'b01:   new_val = csr_wdata_i;
         2'b10:   new_val = rd_val | csr_wdata_i;
         default: new_val = rd_val & ~csr_wdata_i;
      endcase
   end

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mscratch_d = mscratch_q;
      if (trap_valid_i) begin
         mepc_d   = {trap_pc_i[W-1:2], 2'b00};
         mcause_d = trap_cause_i;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_i) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (do_write) begin
         case (csr_addr_i)
            A_MSTATUS: begin
               mie_d  = new_val[3];
               mpie_d = new_val[7];
            end
            A_MTVEC:    mtvec_d    = {new_val[W-1:2], 2'b00};
            A_MSCRATCH: mscratch_d = new_val;
            A_MEPC:     mepc_d     = {new_val[W-1:2], 2'b00};
            A_MCAUSE:   mcause_d   = new_val;
            default:    ;
         endcase
      end
   end

`ifdef YSYX_23060025_CSR_COUNTERS_EN
   // A write to either half wins over that counter's increment; the other half holds.
   always_comb begin
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, retire_i};
      if (do_write) begin
         case (csr_addr_i)
            A_MCYCLE:    mcycle_d   = (W == 32) ? {mcycle_q[63:32], new_val[31:0]} : 64'(new_val);
            A_MCYCLEH:   mcycle_d   = {new_val[31:0], mcycle_q[31:0]};
            A_MINSTRET:  minstret_d = (W == 32) ? {minstret_q[63:32], new_val[31:0]} : 64'(new_val);
            A_MINSTRETH: minstret_d = {new_val[31:0], minstret_q[31:0]};
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`else
   logic unused_retire;
   assign unused_retire = retire_i;
   assign mcycle_q      = '0;
   assign minstret_q    = '0;
   assign mcycle_d      = '0;
   assign minstret_d    = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mscratch_q <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mscratch_q <= mscratch_d;
      end
   end

   assign trap_target_o = mtvec_q;
   assign mret_target_o = mepc_q;
   assign mie_o         = mie_q;
endmodule

// File: tb/tb_ysyx_23060025_csr_unit.sv
// Randomised bench for the CSR unit against an architectural model of the machine CSRs.
module tb_ysyx_23060025_csr_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        csr_valid_i = 1'b0;
   logic [1:0]  csr_op_i = 2'b00;
   logic [11:0] csr_addr_i = 12'h000;
   logic [31:0] csr_wdata_i = '0;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;
   logic        trap_valid_i = 1'b0;
   logic [31:0] trap_cause_i = '0;
   logic [31:0] trap_pc_i = '0;
   logic        mret_i = 1'b0;
   logic        retire_i = 1'b0;
   logic [31:0] trap_target_o, mret_target_o;
   logic        mie_o;

   int errors = 0;
   int checks = 0;

   // Architectural model state.
   bit          m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
   logic [63:0] m_cycle, m_instret;
   logic [31:0] last_rdata;
   logic        last_ill;

   ysyx_23060025_csr_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .csr_valid_i(csr_valid_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
      .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
      .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
      .mret_i(mret_i), .retire_i(retire_i),
      .trap_target_o(trap_target_o), .mret_target_o(mret_target_o), .mie_o(mie_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mie = 0; m_mpie = 0;
      m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
      m_cycle = 0; m_instret = 0;
   endtask

   function automatic void m_read(input logic [11:0] a, output logic [31:0] v,
                                  output bit ok, output bit ro);
      v = 0; ok = 1; ro = 0;
      case (a)
         12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'hF11: begin v = 32'h79737978; ro = 1; end
         12'hF12: begin v = 32'd23060025; ro = 1; end
         12'hF14: begin v = 0; ro = 1; end
`ifdef YSYX_23060025_CSR_COUNTERS_EN
         12'hB00: v = m_cycle[31:0];
         12'hB80: v = m_cycle[63:32];
         12'hB02: v = m_instret[31:0];
         12'hB82: v = m_instret[63:32];
`endif
         default: ok = 0;
      endcase
   endfunction

   // One clock cycle: drive at the falling edge, check reads, clock, update model, check views.
   task automatic step(input bit v, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input bit tr, input logic [31:0] cause,
                       input logic [31:0] pc, input bit mr, input bit ret);
      logic [31:0] ev, nv;
      bit ok, ro, wa, ill, cyc_wr, ins_wr;
      csr_valid_i = v; csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd;
      trap_valid_i = tr; trap_cause_i = cause; trap_pc_i = pc; mret_i = mr; retire_i = ret;
      #1;
      m_read(a, ev, ok, ro);
      wa  = (op == 2'b01) || (op != 2'b00 && wd != 0);
      ill = v && (!ok || (ro && wa));
      check("illegal", 64'(csr_illegal_o), 64'(ill));
      check("rdata", 64'(csr_rdata_o), ill ? 64'd0 : 64'(ev));
      last_rdata = csr_rdata_o;
      last_ill   = csr_illegal_o;
      @(posedge clk);
      nv = (op == 2'b01) ? wd : (op == 2'b10) ? (ev | wd) : (ev & ~wd);
      cyc_wr = 0; ins_wr = 0;
      if (tr) begin
         m_mepc = pc & ~32'h3; m_mcause = cause; m_mpie = m_mie; m_mie = 0;
      end else if (mr) begin
         m_mie = m_mpie; m_mpie = 1;
      end else if (v && !ill && wa) begin
         case (a)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h305: m_mtvec = nv & ~32'h3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'h3;
            12'h342: m_mcause = nv;
            12'hB00: begin m_cycle[31:0] = nv; cyc_wr = 1; end
            12'hB80: begin m_cycle[63:32] = nv; cyc_wr = 1; end
            12'hB02: begin m_instret[31:0] = nv; ins_wr = 1; end
            12'hB82: begin m_instret[63:32] = nv; ins_wr = 1; end
            default: ;
         endcase
      end
      if (!cyc_wr) m_cycle = m_cycle + 1;
      if (!ins_wr && ret) m_instret = m_instret + 1;
      #1;
      check("mie_o", 64'(mie_o), 64'(m_mie));
      check("trap_target", 64'(trap_target_o), 64'(m_mtvec));
      check("mret_target", 64'(mret_target_o), 64'(m_mepc));
      @(negedge clk);
   endtask

   task automatic rd(input logic [11:0] a);
      step(1, 2'b00, a, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
      step(1, op, a, wd, 0, 0, 0, 0, 0);
   endtask

   logic [11:0] pool [13] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF11, 12'hF12,
                              12'hF14, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0};

   initial begin
      model_reset();
      csr_valid_i = 1; csr_addr_i = 12'h300;
      #1;
      check("reset_mstatus_comb", 64'(csr_rdata_o), 64'h1800);
      check("reset_mie", 64'(mie_o), 64'd0);
      check("reset_trap_target", 64'(trap_target_o), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1;

      rd(12'h300);            check("read_mstatus", 64'(last_rdata), 64'h1800);
      rd(12'hF12);            check("read_marchid", 64'(last_rdata), 64'd23060025);
      wr(2'b01, 12'h305, 32'h80000103);
      rd(12'h305);            check("mtvec_aligned", 64'(last_rdata), 64'h80000100);
      check("trap_target_val", 64'(trap_target_o), 64'h80000100);

      wr(2'b10, 12'h300, 32'h8);
      rd(12'h300);            check("mie_set", 64'(last_rdata), 64'h1808);
      step(0, 2'b00, 12'h000, 0, 1, 32'd11, 32'h80000010, 0, 0);
      rd(12'h341);            check("trap_mepc", 64'(last_rdata), 64'h80000010);
      rd(12'h342);            check("trap_mcause", 64'(last_rdata), 64'd11);
      rd(12'h300);            check("trap_mstatus", 64'(last_rdata), 64'h1880);
      step(0, 2'b00, 12'h000, 0, 0, 0, 0, 1, 0);
      rd(12'h300);            check("mret_mstatus", 64'(last_rdata), 64'h1888);

      step(1, 2'b01, 12'h341, 32'hDEAD0000, 1, 32'd5, 32'h80000044, 1, 0);
      rd(12'h341);            check("prio_mepc", 64'(last_rdata), 64'h80000044);
      rd(12'h300);            check("prio_mstatus", 64'(last_rdata), 64'h1880);

      wr(2'b01, 12'hF11, 32'h1234);
      check("ro_write_illegal", 64'(last_ill), 64'd1);
      rd(12'hF11);            check("mvendorid", 64'(last_rdata), 64'h79737978);
      wr(2'b01, 12'h340, 32'h55AA);
      wr(2'b10, 12'h340, 32'h0);
      rd(12'h340);            check("rs_zero_noop", 64'(last_rdata), 64'h55AA);
      wr(2'b11, 12'h340, 32'h000A);
      rd(12'h340);            check("rc_clear", 64'(last_rdata), 64'h55A0);

`ifdef YSYX_23060025_CSR_COUNTERS_EN
      wr(2'b01, 12'hB00, 32'hFFFFFFFF);
      wr(2'b01, 12'hB80, 32'h0);
      rd(12'h000);
      rd(12'h000);
      rd(12'hB00);            check("mcycle_wrap_lo", 64'(last_rdata), 64'd1);
      rd(12'hB80);            check("mcycle_wrap_hi", 64'(last_rdata), 64'd1);
      step(1, 2'b01, 12'hB02, 32'h100, 0, 0, 0, 0, 1);
      rd(12'hB02);            check("minstret_collision", 64'(last_rdata), 64'h100);
`else
      rd(12'hB00);            check("no_counter_illegal", 64'(last_ill), 64'd1);
      rd(12'hB82);            check("no_counterh_illegal", 64'(last_ill), 64'd1);
`endif

      // Asynchronous reset mid-run, coincident with a trap and a write.
      csr_valid_i = 1; csr_op_i = 2'b01; csr_addr_i = 12'h341; csr_wdata_i = 32'h44;
      trap_valid_i = 1; trap_pc_i = 32'h80000200; trap_cause_i = 32'd3;
      #2 rst_n = 0;
      #1;
      check("arst_mret_target", 64'(mret_target_o), 64'd0);
      check("arst_trap_target", 64'(trap_target_o), 64'd0);
      check("arst_rdata", 64'(csr_rdata_o), 64'd0);
      @(posedge clk);
      @(negedge clk);
      trap_valid_i = 0; csr_valid_i = 0;
      rst_n = 1;
      model_reset();
      rd(12'h300);            check("post_reset_mstatus", 64'(last_rdata), 64'h1800);

      for (int i = 0; i < 400; i++) begin
         logic [11:0] a;
         logic [31:0] wd;
         a  = ($urandom_range(0, 15) == 0) ? 12'($urandom) : pool[$urandom_range(0, 12)];
         wd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         step($urandom_range(0, 3) != 0, 2'($urandom), a, wd,
              $urandom_range(0, 7) == 0, $urandom, $urandom,
              $urandom_range(0, 7) == 0, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ysyx_23060025_csr_unit.md
YSYX_23060025_CSR_UNIT -- requirements
Module: ysyx_23060025_csr_unit

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, meaning CSR/XLEN width; only 32 and 64 are legal.
REQ-002 SHALL provide parameter VENDOR_ID, default 32'h79737978, meaning mvendorid read value.
REQ-003 SHALL provide parameter ARCH_ID, default 32'd23060025, meaning marchid read value.
REQ-004 SHALL provide port clock  in  1  sole clock, rising edge.
REQ-005 SHALL provide port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL provide csr_valid_i  in  1; csr_op_i  in  2 (01 RW, 10 RS, 11 RC, 00 read-only access); csr_addr_i  in  12; csr_wdata_i  in  DATA_WIDTH.
REQ-007 SHALL provide csr_rdata_o  out  DATA_WIDTH, old CSR value; csr_illegal_o  out  1, illegal access.
REQ-008 SHALL provide trap_valid_i  in  1; trap_cause_i  in  DATA_WIDTH; trap_pc_i  in  DATA_WIDTH; mret_i  in  1; retire_i  in  1, one instruction retired.
REQ-009 SHALL provide trap_target_o  out  DATA_WIDTH, {mtvec[W-1:2],2'b00}; mret_target_o  out  DATA_WIDTH, mepc; mie_o  out  1, mstatus.MIE.

Function
REQ-010 SHALL implement mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342 as read/write; mvendorid 0xF11, marchid 0xF12, mhartid 0xF14 (value 0) as read-only.
REQ-011 SHALL drive csr_rdata_o combinationally from csr_addr_i in the same cycle; write takes effect at the next rising edge (read-old/write-new).
REQ-012 SHALL compute new value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
REQ-013 SHALL suppress the write for RS/RC when csr_wdata_i == 0 and for op 00; no side effect occurs.
REQ-014 SHALL assert csr_illegal_o when csr_valid_i and (address unimplemented, or a write is attempted to a read-only CSR); csr_rdata_o is then 0 and no state changes.
REQ-015 SHALL implement in mstatus only MIE (bit 3), MPIE (bit 7), MPP (bits 12:11, hardwired 2'b11); all other bits read 0 and ignore writes.
REQ-016 SHALL hardwire mtvec[1:0] and mepc[1:0] to 0 (direct mode, aligned).
REQ-017 SHALL on trap_valid_i: mepc <= trap_pc_i, mcause <= trap_cause_i, MPIE <= MIE, MIE <= 0, all at one edge.
REQ-018 SHALL on mret_i: MIE <= MPIE, MPIE <= 1.
REQ-019 SHALL prioritise simultaneous events: trap_valid_i > mret_i > CSR write; the lower-priority event is dropped entirely that cycle.
REQ-020 SHALL keep trap_target_o, mret_target_o and mie_o as direct register views (zero added latency).

Reset
REQ-021 SHALL on reset low, immediately and independent of clock: mstatus = 32'h1800 (MIE=0, MPIE=0), mtvec = mepc = mcause = mscratch = 0, counters = 0.
REQ-022 SHALL leave all outputs reflecting reset values while reset is low; csr_illegal_o follows its combinational decode.
REQ-023 SHALL drop any trap, mret or write coincident with reset assertion; first state update occurs at the first rising edge after reset deasserts.

Configuration
REQ-024 SHALL, with macro YSYX_23060025_CSR_COUNTERS_EN defined, include 64-bit mcycle (0xB00) and minstret (0xB02); for DATA_WIDTH 32 also mcycleh (0xB80) and minstreth (0xB82) as upper halves.
REQ-025 SHALL increment mcycle every cycle out of reset and minstret on each cycle retire_i is high, wrapping 2^64-1 to 0.
REQ-026 SHALL, on a CSR write to a counter half in the same cycle as its increment, store the written value (no increment that cycle) and keep the other half unchanged.
REQ-027 SHALL, with the macro undefined, omit all counter logic; addresses 0xB00/0xB02/0xB80/0xB82 are then illegal per REQ-014.

Verification
REQ-028 SHALL cover: reset released, read 0x300 -> rdata 32'h1800; read 0xF12 -> 32'd23060025.
REQ-029 SHALL cover: RW 0x305 wdata 32'h80000103, then read -> 32'h80000100; trap_target_o = 32'h80000100.
REQ-030 SHALL cover: MIE=1, trap_valid_i with cause 11, pc 32'h80000010 -> mepc 32'h80000010, mcause 11, MIE 0, MPIE 1; then mret_i -> MIE 1, MPIE 1.
REQ-031 SHALL cover: trap_valid_i, mret_i and RW 0x341 wdata 32'hDEAD0000 in same cycle -> only trap applied, mepc = trap_pc_i.
REQ-032 SHALL cover: RW to 0xF11 -> csr_illegal_o 1, no state change; RS 0x340 with wdata 0 -> mscratch unchanged.
REQ-033 SHALL cover (counters enabled): RW mcycle 32'hFFFFFFFF, mcycleh 0 -> two cycles later mcycleh 1, mcycle 1; write-vs-increment collision stores written value.
